// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 integer register file with write-through read bypass.
// Optional macro WB_PERF_CNT_EN adds a committed-write-back counter on wb_count.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] Read_data_WB,
  input  logic [XLEN-1:0] Address_WB,
  input  logic [4:0]      Rd_WB,
  input  logic            MemtoReg_WB,
  input  logic            RegWrite_WB,
  input  logic [4:0]      Rs1,
  input  logic [4:0]      Rs2,
  output logic [XLEN-1:0] Read_data1,
  output logic [XLEN-1:0] Read_data2,
  output logic [XLEN-1:0] Write_data_WB,
  output logic            WB_valid,
  output logic [31:0]     wb_count
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  assign Write_data_WB = MemtoReg_WB ? Read_data_WB : Address_WB;
  assign wr_en         = RegWrite_WB && (Rd_WB != 5'd0);
  assign WB_valid      = wr_en && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[Rd_WB] <= Write_data_WB;
    end
  end

  // Bypass lets ID see a write-back committing on this same edge.
  always_comb begin
    Read_data1 = regs_q[Rs1];
    if (reset || (Rs1 == 5'd0)) begin
      Read_data1 = '0;
    end else if (wr_en && (Rd_WB == Rs1)) begin
      Read_data1 = Write_data_WB;
    end
  end

  always_comb begin
    Read_data2 = regs_q[Rs2];
    if (reset || (Rs2 == 5'd0)) begin
      Read_data2 = '0;
    end else if (wr_en && (Rd_WB == Rs2)) begin
      Read_data2 = Write_data_WB;
    end
  end

`ifdef WB_PERF_CNT_EN
  logic [31:0] wb_count_q;
  logic [31:0] wb_count_d;

  always_comb begin
    wb_count_d = wb_count_q;
    if (WB_valid) begin
      wb_count_d = wb_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_count_q <= '0;
    end else begin
      wb_count_q <= wb_count_d;
    end
  end

  assign wb_count = wb_count_q;
`else
  assign wb_count = 32'h0;
`endif

endmodule
